// File: rtl/bp_be_stride_detector.sv
// Per-PC load stride table feeding loop inference: reports a striding load once
// its stride is stable (start pulse) and again once it is confirmed.
module bp_be_stride_detector #(
   parameter int vaddr_width_p  = 39,
   parameter int entries_p      = 8,
   parameter int stride_width_p = 12,
   parameter int start_thresh_p = 1,
   parameter int conf_thresh_p  = 3,
   parameter int timeout_p      = 1024
) (
   input  logic                      clk_i,
   input  logic                      reset_n_i,
   input  logic                      ld_v_i,
   input  logic [vaddr_width_p-1:0]  ld_pc_i,
   input  logic [vaddr_width_p-1:0]  ld_eaddr_i,
   output logic                      start_discovery_o,
   output logic                      confirm_discovery_o,
   output logic [vaddr_width_p-1:0]  striding_pc_o,
   output logic [stride_width_p-1:0] stride_o,
   input  logic                      done_i,
   output logic                      busy_o
);

   localparam int idx_w_lp  = $clog2(entries_p);
   localparam int conf_w_lp = $clog2(conf_thresh_p + 1);
   localparam int tmo_w_lp  = $clog2(timeout_p + 1);

   typedef struct packed {
      logic [vaddr_width_p-1:0]  pc;
      logic [vaddr_width_p-1:0]  last_addr;
      logic [stride_width_p-1:0] stride;
      logic [conf_w_lp-1:0]      conf;
   } entry_t;

   typedef enum logic [1:0] {s_idle, s_discover, s_confirmed} state_e;

   logic [entries_p-1:0]      valid_q, valid_d;
   entry_t                    entry_q [entries_p];
   entry_t                    entry_d [entries_p];
   logic [idx_w_lp-1:0]       victim_q, victim_d, track_idx_q, track_idx_d;
   state_e                    state_q, state_d;
   logic [tmo_w_lp-1:0]       tmo_q, tmo_d;
   logic                      start_q, start_d, confirm_q, confirm_d, busy_q, busy_d;
   logic [vaddr_width_p-1:0]  spc_q, spc_d;
   logic [stride_width_p-1:0] sstride_q, sstride_d;

   logic                      hit, fits, match, free_found, trk_hit;
   logic [idx_w_lp-1:0]       hit_idx, free_idx, rr_idx, alloc_idx;
   logic [vaddr_width_p-1:0]  delta;
   logic [conf_w_lp-1:0]      old_conf, new_conf;
   logic [stride_width_p-1:0] new_stride;

   // NOTE: every variable written in always_comb gets a default first, so no path leaves a latch.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < entries_p; i++) begin
         if (valid_q[i] && entry_q[i].pc == ld_pc_i) begin
            hit     = 1'b1;
            hit_idx = idx_w_lp'(i);
         end
      end

      // Delta fits when every bit above the stride sign bit copies that sign bit.
      delta    = ld_eaddr_i - entry_q[hit_idx].last_addr;
      fits     = (&delta[vaddr_width_p-1:stride_width_p-1]) | ~(|delta[vaddr_width_p-1:stride_width_p-1]);
      match    = fits && (delta != '0) && (delta[stride_width_p-1:0] == entry_q[hit_idx].stride);
      old_conf = entry_q[hit_idx].conf;
      if (match) begin
         new_conf   = (old_conf == conf_w_lp'(conf_thresh_p)) ? old_conf : old_conf + 1'b1;
         new_stride = entry_q[hit_idx].stride;
      end else begin
         new_conf   = '0;
         new_stride = fits ? delta[stride_width_p-1:0] : '0;
      end

      free_found = 1'b0;
      free_idx   = '0;
      for (int i = entries_p - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_found = 1'b1;
            free_idx   = idx_w_lp'(i);
         end
      end
      // The tracked entry is stepped over while a discovery is in flight.
      rr_idx    = (busy_q && victim_q == track_idx_q) ? victim_q + 1'b1 : victim_q;
      alloc_idx = free_found ? free_idx : rr_idx;

      valid_d  = valid_q;
      victim_d = victim_q;
      for (int i = 0; i < entries_p; i++) entry_d[i] = entry_q[i];
      if (ld_v_i) begin
         if (hit) begin
            entry_d[hit_idx].last_addr = ld_eaddr_i;
            entry_d[hit_idx].stride    = new_stride;
            entry_d[hit_idx].conf      = new_conf;
         end else begin
            valid_d[alloc_idx] = 1'b1;
            entry_d[alloc_idx] = '{pc: ld_pc_i, last_addr: ld_eaddr_i, stride: '0, conf: '0};
            if (!free_found) victim_d = rr_idx + 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      tmo_d       = tmo_q;
      start_d     = 1'b0;
      confirm_d   = 1'b0;
      spc_d       = spc_q;
      sstride_d   = sstride_q;
      track_idx_d = track_idx_q;
      trk_hit     = ld_v_i && hit && (hit_idx == track_idx_q);
      unique case (state_q)
         s_idle: begin
            if (ld_v_i && hit && old_conf == conf_w_lp'(start_thresh_p - 1)
                && new_conf == conf_w_lp'(start_thresh_p)) begin
               start_d     = 1'b1;
               spc_d       = ld_pc_i;
               sstride_d   = new_stride;
               track_idx_d = hit_idx;
               tmo_d       = '0;
               state_d     = s_discover;
            end
         end
         s_discover: begin
            if (trk_hit) begin
               tmo_d = '0;
               if (new_conf == conf_w_lp'(conf_thresh_p)) begin
                  confirm_d = 1'b1;
                  state_d   = s_confirmed;
               end else if (new_conf == '0) begin
                  state_d = s_idle;
               end
            end else if (ld_v_i) begin
               tmo_d = tmo_q + 1'b1;
               if (tmo_q == tmo_w_lp'(timeout_p - 1)) state_d = s_idle;
            end
         end
         s_confirmed: begin
            if (done_i) state_d = s_idle;
         end
         default: state_d = s_idle;
      endcase
      busy_d = (state_d != s_idle);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         valid_q     <= '0;
         victim_q    <= '0;
         track_idx_q <= '0;
         state_q     <= s_idle;
         tmo_q       <= '0;
         start_q     <= 1'b0;
         confirm_q   <= 1'b0;
         busy_q      <= 1'b0;
         spc_q       <= '0;
         sstride_q   <= '0;
      end else begin
         valid_q     <= valid_d;
         victim_q    <= victim_d;
         track_idx_q <= track_idx_d;
         state_q     <= state_d;
         tmo_q       <= tmo_d;
         start_q     <= start_d;
         confirm_q   <= confirm_d;
         busy_q      <= busy_d;
         spc_q       <= spc_d;
         sstride_q   <= sstride_d;
      end
   end

   // NOTE: the table payload is not reset; valid bits gate it and allocation rewrites it fully.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < entries_p; i++) entry_q[i] <= entry_d[i];
   end

   assign start_discovery_o   = start_q;
   assign confirm_discovery_o = confirm_q;
   assign striding_pc_o       = spc_q;
   assign stride_o            = sstride_q;
   assign busy_o              = busy_q;

endmodule

// File: doc/bp_be_stride_detector.md
Name: bp_be_stride_detector

Overview:
- Upstream feeder of the backend loop-inference unit. Watches committed loads and tracks per-PC address deltas in a small fully associative table.
- When one load shows a stable nonzero stride, it pulses start_discovery and presents the load PC.
- Once that stride reaches the confirmation threshold, it pulses confirm_discovery.
- It then holds off further discoveries until the loop-inference result is consumed.

Parameters:
- vaddr_width_p, 39, virtual address width; also the width of PC and effective address.
- entries_p, 8, number of stride-table entries (power of 2, ≥2).
- stride_width_p, 12, signed stride width held per entry.
- start_thresh_p, 1, confidence value at which discovery starts (≥1).
- conf_thresh_p, 3, confidence value at which discovery is confirmed (> start_thresh_p).
- timeout_p, 1024, committed loads allowed in DISCOVER without a hit on the tracked PC before abort.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- ld_v_i  in  1  committed load valid; at most one per cycle.
- ld_pc_i  in  vaddr_width_p  PC of the committed load.
- ld_eaddr_i  in  vaddr_width_p  effective address of the committed load.
- start_discovery_o  out  1  one-cycle pulse: new striding-load candidate.
- confirm_discovery_o  out  1  one-cycle pulse: candidate stride confirmed.
- striding_pc_o  out  vaddr_width_p  PC of the tracked load; stable outside IDLE.
- stride_o  out  stride_width_p  signed stride of the tracked load.
- done_i  in  1  loop-inference result consumed (yumi).
- busy_o  out  1  high in DISCOVER or CONFIRMED.

Behaviour:
- Reset (asynchronous, while reset_n_i=0):
  - All entries invalid; victim pointer 0; FSM in IDLE; timeout counter 0.
  - All outputs 0.
  - Reset mid-operation abandons any discovery immediately, with no pulse.
- Table entry contents: valid, pc (full width), last_addr, stride (signed), conf (saturating at conf_thresh_p).
- Lookup: exact compare of ld_pc_i against all valid entries. At most one entry can hit because allocation only happens on a miss.
- Hit update, on a cycle with ld_v_i:
  - delta = ld_eaddr_i - last_addr, full width.
  - fits = delta is representable in stride_width_p signed bits.
  - If fits, delta != 0 and delta[stride_width_p-1:0] == stride: conf increments, saturating.
  - Otherwise: stride <= fits ? delta[stride_width_p-1:0] : 0, and conf <= 0.
  - last_addr <= ld_eaddr_i in both cases.
- Miss:
  - Allocate into the lowest-index invalid entry; if none is invalid, use the round-robin victim pointer, which then increments mod entries_p.
  - New entry: pc = ld_pc_i, last_addr = ld_eaddr_i, stride = 0, conf = 0.
  - The entry holding striding_pc_o is never victimised while busy_o=1; the pointer skips it.
- Table updates happen in every FSM state.
- All outputs are registered. Pulses appear the cycle after the triggering ld_v_i cycle.
- FSM, IDLE:
  - If a hit update moves conf from start_thresh_p-1 to start_thresh_p: pulse start_discovery_o, latch striding_pc_o and stride_o, clear the timeout counter, go to DISCOVER.
- FSM, DISCOVER:
  - Hit on the tracked PC whose update moves conf to conf_thresh_p: pulse confirm_discovery_o, go to CONFIRMED.
  - Hit on the tracked PC that resets conf to 0: abort to IDLE with no pulse.
  - Each ld_v_i that is not a tracked-PC hit increments the timeout counter. At timeout_p, go to IDLE.
  - The timeout counter clears on each tracked-PC hit.
  - done_i is ignored.
- FSM, CONFIRMED:
  - Wait for done_i, then go to IDLE next cycle.
  - Other entries reaching start_thresh_p are not reported.
  - Tracked-entry conf dropping here does not abort.
- Simultaneous events:
  - done_i in CONFIRMED with a same-cycle threshold crossing: return to IDLE only, no start pulse. The entry must re-cross the threshold later.
  - start_thresh_p threshold crossing only counts in IDLE. An entry already at conf ≥ start_thresh_p does not re-trigger until conf resets and climbs again.
- start_discovery_o and confirm_discovery_o are never high in the same cycle.

Test Plan:
- Start/confirm sequence: pc 0x1000 loads addrs 0x2000, 0x2008, 0x2010, 0x2018, 0x2020.
  - start pulse one cycle after the 3rd load, with striding_pc_o=0x1000 and stride_o=8.
  - confirm pulse one cycle after the 5th load.
  - busy_o=1 until the cycle after done_i.
- Stride break: pc 0x1000 at 0x2000, 0x2008, 0x2010 (start), then 0x3000.
  - Return to IDLE, no confirm, busy_o=0.
  - Entry stride becomes 0 because 0xFF0 does not fit 12 bits signed.
- Negative and zero stride:
  - pc 0x40 addrs 0x500, 0x4F8, 0x4F0: start with stride_o=0xFF8 (-8).
  - pc 0x80 repeating 0x600: never starts.
- Replacement: 9 distinct PCs while pc 0x1000 is tracked in DISCOVER.
  - The tracked entry survives, and a later 0x1000 hit still confirms.
- Timeout: start on 0x1000, then 1024 loads from other PCs.
  - IDLE after the 1024th with no confirm; a new candidate can start afterwards.
- Async reset asserted mid-DISCOVER, between clock edges:
  - Outputs drop to 0 immediately.
  - After release, the previously tracked PC needs 3 new loads to start again.
